// File: rtl/alu_pkg.sv
// Shared types and constants for the multicycle execute-stage ALU.
package alu_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int STEP_CNT_W = 5;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_MUL  = 3'b100,
        ALU_SLT  = 3'b101,
        ALU_DIVU = 3'b110,
        ALU_REMU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_e;

    function automatic logic is_iter_op(input alu_op_e op);
        return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/muldiv_iter.sv
// One-bit-per-step shift-add multiplier and restoring divider.
// The *_o outputs show what the registers take on the next step edge.
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int W = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic         step_i,
    input  logic [2:0]   op_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] prod_o,
    output logic [W-1:0] quot_o,
    output logic [W-1:0] rem_o
);

    logic         is_mul_q;
    logic [W-1:0] acc_q;
    logic [W-1:0] mcand_q;
    logic [W-1:0] mplier_q;
    logic [W-1:0] rem_q;
    logic [W-1:0] quot_q;
    logic [W-1:0] divisor_q;

    logic [W-1:0] acc_d;
    logic [W:0]   shifted;
    logic [W:0]   trial;
    logic [W-1:0] rem_d;
    logic [W-1:0] quot_d;

    // A borrow out of the trial subtraction means the divisor did not fit;
    // with a zero divisor it always fits, giving all-ones quotient and rem = dividend.
    always_comb begin
        acc_d   = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        shifted = {rem_q, quot_q[W-1]};
        trial   = shifted - {1'b0, divisor_q};
        rem_d   = trial[W] ? shifted[W-1:0] : trial[W-1:0];
        quot_d  = {quot_q[W-2:0], ~trial[W]};
    end

    assign prod_o = acc_d;
    assign quot_o = quot_d;
    assign rem_o  = rem_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            is_mul_q  <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            divisor_q <= '0;
        end else if (load_i) begin
            is_mul_q  <= (alu_op_e'(op_i) == ALU_MUL);
            acc_q     <= '0;
            mcand_q   <= a_i;
            mplier_q  <= b_i;
            rem_q     <= '0;
            quot_q    <= a_i;
            divisor_q <= b_i;
        end else if (step_i) begin
            if (is_mul_q) begin
                acc_q    <= acc_d;
                mcand_q  <= {mcand_q[W-2:0], 1'b0};
                mplier_q <= {1'b0, mplier_q[W-1:1]};
            end else begin
                rem_q  <= rem_d;
                quot_q <= quot_d;
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Execute-stage ALU: single-cycle logic/arith ops, 32-step MUL/DIVU/REMU,
// start/done handshake with a registered result and zero flag.
module multicycle_alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            ALUctrl,
    input  logic [DATA_WIDTH-1:0] ALUop1,
    input  logic [DATA_WIDTH-1:0] ALUop2,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] ALUout,
    output logic                  EQ
);

    localparam logic [STEP_CNT_W-1:0] LAST_STEP = STEP_CNT_W'(DATA_WIDTH - 1);

    state_e                  state_q, state_d;
    logic [STEP_CNT_W-1:0]   cnt_q, cnt_d;
    alu_op_e                 op_q, op_d;
    logic [DATA_WIDTH-1:0]   out_q, out_d;
    logic                    eq_q, eq_d;

    alu_op_e                 op_in;
    logic [DATA_WIDTH-1:0]   sc_res;
    logic                    md_load;
    logic                    md_step;
    logic [DATA_WIDTH-1:0]   md_prod;
    logic [DATA_WIDTH-1:0]   md_quot;
    logic [DATA_WIDTH-1:0]   md_rem;

    assign op_in = alu_op_e'(ALUctrl);

    always_comb begin
        sc_res = '0;
        case (op_in)
            ALU_ADD: sc_res = ALUop1 + ALUop2;
            ALU_SUB: sc_res = ALUop1 - ALUop2;
            ALU_AND: sc_res = ALUop1 & ALUop2;
            ALU_OR:  sc_res = ALUop1 | ALUop2;
            ALU_SLT: sc_res = {{(DATA_WIDTH-1){1'b0}}, ($signed(ALUop1) < $signed(ALUop2))};
            default: sc_res = '0;
        endcase
    end

    muldiv_iter #(.W(DATA_WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .load_i (md_load),
        .step_i (md_step),
        .op_i   (ALUctrl),
        .a_i    (ALUop1),
        .b_i    (ALUop2),
        .prod_o (md_prod),
        .quot_o (md_quot),
        .rem_o  (md_rem)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        out_d   = out_q;
        md_load = 1'b0;
        md_step = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (is_iter_op(op_in)) begin
                        state_d = S_RUN;
                        op_d    = op_in;
                        cnt_d   = '0;
                        md_load = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        out_d   = sc_res;
                    end
                end
            end
            S_RUN: begin
                md_step = 1'b1;
                cnt_d   = cnt_q + 1'b1;
                // The last step's result goes straight into ALUout on the same edge.
                if (cnt_q == LAST_STEP) begin
                    state_d = S_DONE;
                    case (op_q)
                        ALU_MUL:  out_d = md_prod;
                        ALU_DIVU: out_d = md_quot;
                        default:  out_d = md_rem;
                    endcase
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        eq_d = (out_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= ALU_ADD;
            out_q   <= '0;
            eq_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            out_q   <= out_d;
            eq_q    <= eq_d;
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign done   = (state_q == S_DONE);
    assign ALUout = out_q;
    assign EQ     = eq_q;

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu.
module tb_multicycle_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  ALUctrl;
    logic [31:0] ALUop1;
    logic [31:0] ALUop2;
    logic        busy;
    logic        done;
    logic [31:0] ALUout;
    logic        EQ;

    int n_checks = 0;
    int n_bad    = 0;

    multicycle_alu #(.DATA_WIDTH(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .ALUctrl (ALUctrl),
        .ALUop1  (ALUop1),
        .ALUop2  (ALUop2),
        .busy    (busy),
        .done    (done),
        .ALUout  (ALUout),
        .EQ      (EQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Issue one op, scramble inputs afterwards, and check latency, busy, result, EQ and single pulse.
    task automatic run_op(input string tag, input logic [2:0] ctrl, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
        int   lat;
        logic busy_ok;
        @(negedge clk);
        start = 1'b1; ALUctrl = ctrl; ALUop1 = a; ALUop2 = b;
        @(negedge clk);
        start = 1'b0; ALUctrl = 3'b000; ALUop1 = $urandom; ALUop2 = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (!done && lat < 100) begin
            if (!busy) busy_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (!busy) busy_ok = 1'b0;
        check_val({tag, " latency"}, lat, exp_lat);
        check_val({tag, " busy"}, {31'd0, busy_ok}, 32'd1);
        check_val({tag, " ALUout"}, ALUout, exp);
        check_val({tag, " EQ"}, {31'd0, EQ}, {31'd0, (exp == 32'd0)});
        $display("%s: op=%0d a=%h b=%h out=%h eq=%0b lat=%0d", tag, ctrl, a, b, ALUout, EQ, lat);
        @(negedge clk);
        check_val({tag, " done pulse end"}, {31'd0, done}, 32'd0);
        check_val({tag, " idle busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin : stim
        int done_cnt;
        int done_k;
        logic [31:0] done_val;

        rst = 1'b1; start = 1'b0; ALUctrl = 3'b000; ALUop1 = '0; ALUop2 = '0;
        repeat (2) @(negedge clk);
        check_val("reset busy", {31'd0, busy}, 32'd0);
        check_val("reset done", {31'd0, done}, 32'd0);
        check_val("reset ALUout", ALUout, 32'd0);
        check_val("reset EQ", {31'd0, EQ}, 32'd1);
        $display("reset: busy=%0b done=%0b out=%h eq=%0b", busy, done, ALUout, EQ);

        // Reset wins over a simultaneous start.
        start = 1'b1; ALUctrl = 3'b000; ALUop1 = 32'd3; ALUop2 = 32'd4;
        @(negedge clk);
        check_val("rst vs start busy", {31'd0, busy}, 32'd0);
        check_val("rst vs start ALUout", ALUout, 32'd0);
        $display("rst+start: busy=%0b out=%h", busy, ALUout);
        rst = 1'b0; start = 1'b0;

        run_op("ADD 5+7",      3'b000, 32'd5,        32'd7,        32'd12,        1);
        run_op("SUB 9-9",      3'b001, 32'd9,        32'd9,        32'd0,         1);
        run_op("SLT -1<1",     3'b101, 32'hFFFFFFFF, 32'd1,        32'd1,         1);
        run_op("SLT 1<-1",     3'b101, 32'd1,        32'hFFFFFFFF, 32'd0,         1);
        run_op("ADD wrap",     3'b000, 32'hFFFFFFFF, 32'd1,        32'd0,         1);
        run_op("AND",          3'b010, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
        run_op("OR",           3'b011, 32'hF000_0001, 32'h0000_1000, 32'hF000_1001, 1);
        run_op("MUL ffff*3",   3'b100, 32'hFFFFFFFF, 32'd3,        32'hFFFFFFFD,  33);
        run_op("MUL 1234*5678",3'b100, 32'd1234,     32'd5678,     32'd7006652,   33);
        run_op("DIVU 100/7",   3'b110, 32'd100,      32'd7,        32'd14,        33);
        run_op("REMU 100/7",   3'b111, 32'd100,      32'd7,        32'd2,         33);
        run_op("DIVU 13/0",    3'b110, 32'd13,       32'd0,        32'hFFFFFFFF,  33);
        run_op("REMU 13/0",    3'b111, 32'd13,       32'd0,        32'd13,        33);

        // Start while busy must be ignored.
        @(negedge clk);
        start = 1'b1; ALUctrl = 3'b100; ALUop1 = 32'd6; ALUop2 = 32'd7;
        done_cnt = 0; done_k = 0; done_val = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                if (done_k == 0) begin
                    done_k   = k;
                    done_val = ALUout;
                end
            end
            if (k == 1) start = 1'b0;
            if (k == 5) begin
                start = 1'b1; ALUctrl = 3'b000; ALUop1 = 32'd100; ALUop2 = 32'd200;
            end
            if (k == 6) start = 1'b0;
        end
        check_val("MUL busy-start done cycle", done_k, 33);
        check_val("MUL busy-start pulses", done_cnt, 1);
        check_val("MUL busy-start ALUout", done_val, 32'd42);
        $display("MUL 6*7 with start in RUN: done_k=%0d pulses=%0d out=%h", done_k, done_cnt, done_val);

        // Reset in the middle of a division.
        @(negedge clk);
        start = 1'b1; ALUctrl = 3'b110; ALUop1 = 32'd100; ALUop2 = 32'd7;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        check_val("DIVU abort pre busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check_val("DIVU abort busy", {31'd0, busy}, 32'd0);
        check_val("DIVU abort done", {31'd0, done}, 32'd0);
        check_val("DIVU abort ALUout", ALUout, 32'd0);
        check_val("DIVU abort EQ", {31'd0, EQ}, 32'd1);
        rst = 1'b0;
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check_val("DIVU abort no done", done_cnt, 0);
        $display("DIVU reset at RUN 10: busy=%0b out=%h eq=%0b late_done=%0d", busy, ALUout, EQ, done_cnt);

        run_op("ADD 2+2",      3'b000, 32'd2,        32'd2,        32'd4,         1);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
